// File: rtl/sb_drive_sequencer.sv
// Timed drive-manoeuvre sequencer: queues (op, duration) commands and plays them out on the
// motor turn code, inserting a stop dead-time whenever the drive direction changes.
module sb_drive_sequencer #(
  parameter int TICK_DIV = 50_000,
  parameter int DUR_W    = 12,
  parameter int QDEPTH   = 4,
  parameter int DEAD_TK  = 20,
  localparam int AW      = $clog2(QDEPTH),
  localparam int CW      = AW + 1
) (
  input  logic             clk_50,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [DUR_W-1:0] cmd_dur,
  input  logic             abort,
  output logic [2:0]       turn,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    q_count
);

  localparam int         PW      = $clog2(TICK_DIV + 1);
  localparam logic [2:0] OP_STOP = 3'b000;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DEAD, S_RUN, S_DONE} state_t;

  typedef struct packed {
    logic [2:0]       op;
    logic [DUR_W-1:0] dur;
  } cmd_t;

  state_t           state;
  cmd_t             mem [QDEPTH];
  cmd_t             head;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [2:0]       op_r, last_op;
  logic [DUR_W-1:0] dur_r, ticks;
  logic [PW-1:0]    presc;
  logic             push, pop, tick_end, dead_end, run_end, reverse;

  // Unused opcodes 101-111 are played out as stop.
  function automatic logic [2:0] norm_op(input logic [2:0] op);
    return (op > 3'b100) ? OP_STOP : op;
  endfunction

  assign cmd_ready = (count != CW'(QDEPTH)) && !abort && !reset;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (count != '0) && ((state == S_IDLE) || (state == S_DONE)) && !abort && !reset;
  assign head      = mem[rd_ptr];
  assign tick_end  = (presc == PW'(TICK_DIV - 1));
  assign dead_end  = tick_end && (ticks == DUR_W'(DEAD_TK - 1));
  // A zero duration drives continuously until another command is waiting.
  assign run_end   = (dur_r == '0) ? (count != '0) : (tick_end && (ticks == dur_r - 1'b1));
  assign reverse   = (op_r != last_op) && (op_r != OP_STOP) && (last_op != OP_STOP);
  assign busy      = (state != S_IDLE) || (count != '0);
  assign q_count   = count;

  // NOTE: the command store has no reset; count and the pointers decide what is valid, so stale entries are never read.
  always_ff @(posedge clk_50) begin
    if (push) mem[wr_ptr] <= {cmd_op, cmd_dur};
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state   <= S_IDLE;
      turn    <= OP_STOP;
      done    <= 1'b0;
      op_r    <= OP_STOP;
      dur_r   <= '0;
      last_op <= OP_STOP;
      presc   <= '0;
      ticks   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else if (abort) begin
      // Flush and stop at once; last_op is kept so the next reversal still gets its dead-time.
      state  <= S_IDLE;
      turn   <= OP_STOP;
      done   <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      done <= 1'b0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      if (tick_end) begin
        presc <= '0;
        ticks <= ticks + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end

      case (state)
        S_IDLE: begin
          turn <= OP_STOP;
          if (pop) begin
            state <= S_LOAD;
            op_r  <= norm_op(head.op);
            dur_r <= head.dur;
          end
        end
        S_LOAD: begin
          presc <= '0;
          ticks <= '0;
          if (reverse) begin
            state <= S_DEAD;
            turn  <= OP_STOP;
          end else begin
            state <= S_RUN;
            turn  <= op_r;
            if (op_r != OP_STOP) last_op <= op_r;
          end
        end
        S_DEAD: begin
          if (dead_end) begin
            state   <= S_RUN;
            presc   <= '0;
            ticks   <= '0;
            turn    <= op_r;
            last_op <= op_r;
          end
        end
        S_RUN: begin
          if (run_end) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          // turn is left alone here so back-to-back identical ops never glitch through stop.
          if (pop) begin
            state <= S_LOAD;
            op_r  <= norm_op(head.op);
            dur_r <= head.dur;
          end else begin
            state <= S_IDLE;
            turn  <= OP_STOP;
          end
        end
        default: begin
          state <= S_IDLE;
          turn  <= OP_STOP;
        end
      endcase
    end
  end

endmodule
